// File: rtl/gate_test_pkg.sv
// Shared types and constants for the 2-input gate test sequencer.
// Provides the FSM state encoding and reference truth tables.
package gate_test_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Bit i is the expected Y for vector index i = {A,B}.
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NOR  = 4'b0001;

endpackage

// File: rtl/gate_test_sequencer_settle_counter.sv
// Load/decrement dwell counter with a terminal-count flag.
// Ports: i_clk, i_rst (sync, active-high), i_load/i_load_val (preset),
//        i_dec (count down, stops at zero), o_tc (count is zero).
module settle_counter #(
    parameter int W = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/gate_test_sequencer.sv
// Sweeps a 2-input gate through 00,01,10,11 and checks Y against a
// truth table latched on start; reports pass, error count, fail map.
// Ports: i_clk, i_rst (sync, active-high), i_start, i_abort,
//        i_truth_table[3:0], o_gate_a/o_gate_b (gate stimulus),
//        i_gate_y (gate response), o_busy, o_done (1-cycle pulse),
//        o_pass, o_err_count[ERR_W-1:0] (saturating), o_fail_vec[3:0].
module gate_test_sequencer
    import gate_test_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int N_PASSES      = 1,
    parameter int ERR_W         = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [3:0]       i_truth_table,
    output logic             o_gate_a,
    output logic             o_gate_b,
    input  logic             i_gate_y,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_pass,
    output logic [ERR_W-1:0] o_err_count,
    output logic [3:0]       o_fail_vec
);

    localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int PW = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;

    state_t           r_state;
    logic [1:0]       r_idx;
    logic [PW-1:0]    r_pcnt;
    logic [3:0]       r_tt;
    logic [ERR_W-1:0] r_err;
    logic [3:0]       r_fail;
    logic             r_pass;
    logic [1:0]       r_gate_ab;

    state_t           w_state_n;
    logic [1:0]       w_idx_n;
    logic [PW-1:0]    w_pcnt_n;
    logic [3:0]       w_tt_n;
    logic [ERR_W-1:0] w_err_n;
    logic [3:0]       w_fail_n;
    logic             w_pass_n;
    logic [1:0]       w_gate_n;
    logic             w_load;
    logic             w_dec;
    logic             w_tc;
    logic             w_mismatch;
    logic             w_last;
    logic [ERR_W-1:0] w_err_inc;

    settle_counter #(
        .W (CW)
    ) u_settle (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_load),
        .i_load_val (CW'(SETTLE_CYCLES - 1)),
        .i_dec      (w_dec),
        .o_tc       (w_tc)
    );

    assign w_mismatch = (i_gate_y != r_tt[r_idx]);
    assign w_last     = (r_idx == 2'd3) && (r_pcnt == PW'(N_PASSES - 1));
    assign w_err_inc  = (r_err == '1) ? r_err : r_err + 1'b1;

    always_comb begin
        w_state_n = r_state;
        w_idx_n   = r_idx;
        w_pcnt_n  = r_pcnt;
        w_tt_n    = r_tt;
        w_err_n   = r_err;
        w_fail_n  = r_fail;
        w_pass_n  = r_pass;
        w_gate_n  = r_gate_ab;
        w_load    = 1'b0;
        w_dec     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_tt_n    = i_truth_table;
                    w_err_n   = '0;
                    w_fail_n  = '0;
                    w_pass_n  = 1'b0;
                    w_idx_n   = 2'd0;
                    w_pcnt_n  = '0;
                    w_gate_n  = 2'd0;
                    w_load    = 1'b1;
                    w_state_n = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                w_dec = 1'b1;
                if (w_tc) begin
                    w_state_n = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (w_mismatch) begin
                    w_fail_n[r_idx] = 1'b1;
                    w_err_n         = w_err_inc;
                end
                if (w_last) begin
                    // Pass is decided on the final compare's result so it
                    // is already valid while done is high.
                    w_pass_n  = (w_err_n == '0);
                    w_gate_n  = 2'd0;
                    w_state_n = ST_DONE;
                end else begin
                    w_idx_n = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_pcnt_n = r_pcnt + 1'b1;
                    end
                    w_gate_n  = w_idx_n;
                    w_load    = 1'b1;
                    w_state_n = ST_DRIVE;
                end
            end
            ST_DONE: begin
                w_state_n = ST_IDLE;
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        // Abort discards the in-flight compare but keeps partial results.
        if (i_abort && (r_state != ST_IDLE)) begin
            w_state_n = ST_IDLE;
            w_gate_n  = 2'd0;
            w_pass_n  = 1'b0;
            w_err_n   = r_err;
            w_fail_n  = r_fail;
            w_load    = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_pcnt    <= '0;
            r_tt      <= 4'd0;
            r_err     <= '0;
            r_fail    <= 4'd0;
            r_pass    <= 1'b0;
            r_gate_ab <= 2'd0;
        end else begin
            r_state   <= w_state_n;
            r_idx     <= w_idx_n;
            r_pcnt    <= w_pcnt_n;
            r_tt      <= w_tt_n;
            r_err     <= w_err_n;
            r_fail    <= w_fail_n;
            r_pass    <= w_pass_n;
            r_gate_ab <= w_gate_n;
        end
    end

    assign o_gate_a    = r_gate_ab[1];
    assign o_gate_b    = r_gate_ab[0];
    assign o_busy      = (r_state != ST_IDLE);
    assign o_done      = (r_state == ST_DONE);
    assign o_pass      = r_pass;
    assign o_err_count = r_err;
    assign o_fail_vec  = r_fail;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: two instances (1 pass / 4-bit count and
// 2 passes / 2-bit count) driven by the same directed + random runs.
module tb_gate_test_sequencer;
    import gate_test_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] tt_in = 4'd0;
    logic [3:0] gtt   = 4'd0;

    logic       ga_a, gb_a, y_a, busy_a, done_a, pass_a;
    logic [3:0] err_a, fail_a;
    logic       ga_b, gb_b, y_b, busy_b, done_b, pass_b;
    logic [1:0] err_b;
    logic [3:0] fail_b;

    // Behavioural gate under test: gtt[{A,B}] is its output.
    assign y_a = gtt[{ga_a, gb_a}];
    assign y_b = gtt[{ga_b, gb_b}];

    gate_test_sequencer #(
        .SETTLE_CYCLES (2),
        .N_PASSES      (1),
        .ERR_W         (4)
    ) dut_a (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_truth_table (tt_in),
        .o_gate_a      (ga_a),
        .o_gate_b      (gb_a),
        .i_gate_y      (y_a),
        .o_busy        (busy_a),
        .o_done        (done_a),
        .o_pass        (pass_a),
        .o_err_count   (err_a),
        .o_fail_vec    (fail_a)
    );

    gate_test_sequencer #(
        .SETTLE_CYCLES (2),
        .N_PASSES      (2),
        .ERR_W         (2)
    ) dut_b (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_abort       (abort),
        .i_truth_table (tt_in),
        .o_gate_a      (ga_b),
        .o_gate_b      (gb_b),
        .i_gate_y      (y_b),
        .o_busy        (busy_b),
        .o_done        (done_b),
        .o_pass        (pass_b),
        .o_err_count   (err_b),
        .o_fail_vec    (fail_b)
    );

    localparam int S = 2;
    int         np[2]   = '{1, 2};
    int         emax[2] = '{15, 3};
    int         tot[2];
    int         mism[2];
    logic [3:0] mfail[2];
    logic [3:0] tt_lat;

    int n_cmp = 0;
    int n_mis = 0;
    int cur_k = 0;

    task automatic chk(input string tag, input int inst,
                       input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s[%0d] k=%0d observed=%0h expected=%0h",
                   tag, inst, cur_k, obs, exp);
        end
    endtask

    // Expected outputs for cycle k after start (start sampled at cycle 0).
    task automatic check_inst(input int i, input int k,
                              input int ka, input int kr);
        logic [1:0] o_ab, e_ab;
        logic       o_bsy, o_dn, o_ps, e_bsy, e_dn, e_ps;
        logic [7:0] o_err;
        logic [3:0] o_fl, e_fl;
        int         e_err;
        bit         dead, ab;
        if (i == 0) begin
            o_ab = {ga_a, gb_a}; o_bsy = busy_a; o_dn = done_a;
            o_ps = pass_a; o_err = {4'd0, err_a}; o_fl = fail_a;
        end else begin
            o_ab = {ga_b, gb_b}; o_bsy = busy_b; o_dn = done_b;
            o_ps = pass_b; o_err = {6'd0, err_b}; o_fl = fail_b;
        end
        dead  = (kr > 0) && (kr < k);
        ab    = (ka > 0) && (ka < k) && (ka <= tot[i] + 1);
        e_err = (mism[i] > emax[i]) ? emax[i] : mism[i];
        e_fl  = mfail[i];
        e_ab  = 2'd0;
        e_bsy = 1'b0;
        e_dn  = 1'b0;
        e_ps  = 1'b0;
        if (dead) begin
            e_err = 0;
            e_fl  = 4'd0;
        end else if (ab) begin
            e_ps = 1'b0;
        end else if (k <= tot[i]) begin
            e_ab  = 2'(((k - 1) / (S + 1)) % 4);
            e_bsy = 1'b1;
        end else if (k == tot[i] + 1) begin
            e_bsy = 1'b1;
            e_dn  = 1'b1;
            e_ps  = (mism[i] == 0);
        end else begin
            e_ps = (mism[i] == 0);
        end
        chk("gate_ab", i, {6'd0, o_ab}, {6'd0, e_ab});
        chk("busy", i, {7'd0, o_bsy}, {7'd0, e_bsy});
        chk("done", i, {7'd0, o_dn}, {7'd0, e_dn});
        chk("pass", i, {7'd0, o_ps}, {7'd0, e_ps});
        chk("err_count", i, o_err, 8'(e_err));
        chk("fail_vec", i, {4'd0, o_fl}, {4'd0, e_fl});
    endtask

    // Account for a compare happening at the end of cycle k.
    task automatic model_step(input int i, input int k,
                              input int ka, input int kr);
        int v;
        if ((kr > 0) && (kr <= k)) return;
        if ((ka > 0) && (ka <= k) && (ka <= tot[i] + 1)) return;
        if ((k <= tot[i]) && ((k % (S + 1)) == 0)) begin
            v = ((k - 1) / (S + 1)) % 4;
            if (gtt[v] != tt_lat[v]) begin
                mism[i]++;
                mfail[i][v] = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        cur_k = -1;
        mism  = '{0, 0};
        mfail = '{4'd0, 4'd0};
        check_inst(0, 100, 0, 1);
        check_inst(1, 100, 0, 1);
        rst = 1'b0;
    endtask

    task automatic run(input logic [3:0] g, input logic [3:0] t,
                       input int ka, input int kr, input logic [31:0] spam);
        do_reset();
        gtt    = g;
        start  = 1'b1;
        tt_in  = t;
        tt_lat = t;
        for (int k = 1; k <= 27; k++) begin
            @(negedge clk);
            cur_k = k;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            tt_in = 4'($urandom);
            check_inst(0, k, ka, kr);
            check_inst(1, k, ka, kr);
            model_step(0, k, ka, kr);
            model_step(1, k, ka, kr);
            if (k == ka) abort = 1'b1;
            if (k == kr) rst = 1'b1;
            if (spam[k] && (k <= 13) && (ka == 0 || k <= ka) &&
                (kr == 0 || k < kr)) start = 1'b1;
        end
    endtask

    initial begin
        int         ka, kr, mode;
        logic [3:0] g, t;
        tot[0] = 4 * np[0] * (S + 1);
        tot[1] = 4 * np[1] * (S + 1);

        run(TT_NAND, TT_NAND, 0, 0, 32'd0);
        run(4'b0000, TT_NAND, 0, 0, 32'd0);
        run(TT_NAND, TT_AND, 0, 0, 32'd0);
        run(TT_NAND, TT_NAND, 5, 0, 32'h0000_0010);
        run(TT_XOR, TT_XOR, 0, 0, 32'h0000_2000);
        run(TT_NAND, TT_NAND, 0, 7, 32'd0);
        run(TT_NOR, TT_OR, 0, 0, 32'd0);

        for (int n = 0; n < 20; n++) begin
            g    = 4'($urandom);
            t    = ($urandom_range(0, 1) == 0) ? g : 4'($urandom);
            mode = $urandom_range(0, 2);
            ka   = 0;
            kr   = 0;
            if (mode != 0) begin
                do begin
                    ka = $urandom_range(1, 24);
                end while ((ka % 3) == 0 || ka == 13);
                if (mode == 2) begin
                    kr = ka;
                    ka = 0;
                end
            end
            run(g, t, ka, kr, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end

endmodule
